updi_instr_sequencer: RTL and testbench

Command-level controller for the UPDI PHY. It accepts one UPDI instruction at a time (BREAK, LDCS, STCS, LDS, STS) from the programming engine. It sequences the PHY's double-break, TX FIFO and RX FIFO to execute that instruction, then returns one response word carrying read data and a status code. It sits between the programmer FSM and `updi_phy`, and is the only agent driving the PHY's FIFO and double-break ports.

---
 rtl/updi_seq_pkg.sv | 87 ++++++++
 rtl/updi_instr_sequencer_timer.sv | 40 ++++
 rtl/updi_instr_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_updi_instr_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/updi_seq_pkg.sv
// updi_seq_pkg: shared types and constants for the UPDI sequencer.
// Holds command/status/state enums and the TX byte-list helpers.
package updi_seq_pkg;

    typedef enum logic [2:0] {
        CMD_BREAK = 3'd0,
        CMD_LDCS  = 3'd1,
        CMD_STCS  = 3'd2,
        CMD_LDS   = 3'd3,
        CMD_STS   = 3'd4
    } updi_cmd_op;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_TIMEOUT = 2'd1,
        RSP_RXERR   = 2'd2,
        RSP_NACK    = 2'd3
    } updi_rsp_status;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_TX,
        ST_RX_WAIT,
        ST_CHECK,
        ST_BRK_START,
        ST_BRK_WAIT,
        ST_DONE
    } updi_seq_state;

    localparam logic [7:0] UPDI_SYNC = 8'h55;
    localparam logic [7:0] UPDI_ACK  = 8'h40;
    localparam logic [7:0] OPC_LDCS  = 8'h80;
    localparam logic [7:0] OPC_STCS  = 8'hC0;
    localparam logic [7:0] OPC_LDS16 = 8'h04;
    localparam logic [7:0] OPC_STS16 = 8'h44;

    // Index of the final byte of the TX list for an op and STS phase.
    function automatic logic [1:0] tx_last_idx(
        input logic [2:0] op,
        input logic       phase2
    );
        logic [1:0] last;
        case (op)
            CMD_LDCS: last = 2'd1;
            CMD_STCS: last = 2'd2;
            CMD_LDS:  last = 2'd3;
            CMD_STS:  last = phase2 ? 2'd0 : 2'd3;
            default:  last = 2'd0;
        endcase
        return last;
    endfunction

    // Byte at position idx of the TX list for an op and STS phase.
    function automatic logic [7:0] tx_byte(
        input logic [2:0]  op,
        input logic        phase2,
        input logic [1:0]  idx,
        input logic [15:0] addr,
        input logic [7:0]  wdata
    );
        logic [7:0] b;
        logic [7:0] cs;
        cs = {4'h0, addr[3:0]};
        b  = 8'h00;
        if (op == CMD_STS && phase2) begin
            b = wdata;
        end else if (idx == 2'd0) begin
            b = UPDI_SYNC;
        end else begin
            case (op)
                CMD_LDCS: b = OPC_LDCS | cs;
                CMD_STCS: b = (idx == 2'd1) ? (OPC_STCS | cs) : wdata;
                CMD_LDS, CMD_STS: begin
                    case (idx)
                        2'd1:    b = (op == CMD_LDS) ? OPC_LDS16 : OPC_STS16;
                        2'd2:    b = addr[7:0];
                        default: b = addr[15:8];
                    endcase
                end
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/updi_instr_sequencer_timer.sv
// updi_resp_timer: response wait counter with clear, enable and expiry.
// Expiry flags the cycle in which the count reaches the limit.
module updi_resp_timer #(
    parameter int RESP_TIMEOUT_CLK = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(RESP_TIMEOUT_CLK + 1);
    localparam logic [W-1:0] LIMIT = W'(RESP_TIMEOUT_CLK);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired_o = en_i && !clr_i && (cnt_d == LIMIT);

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/updi_instr_sequencer.sv
// updi_instr_sequencer: runs one UPDI instruction at a time on the PHY
// FIFOs and double-break port, then returns one response word.
module updi_instr_sequencer
    import updi_seq_pkg::*;
#(
    parameter int RESP_TIMEOUT_CLK = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic [7:0]  tx_data,
    output logic        tx_wr_en,
    input  logic        tx_full,
    input  logic [7:0]  rx_data,
    output logic        rx_rd_en,
    input  logic        rx_empty,
    input  logic        rx_error,
    output logic        brk_start,
    input  logic        brk_busy,
    input  logic        brk_done
);

    updi_seq_state  state_q, state_d;
    updi_rsp_status status_q, status_d;
    logic [2:0]     op_q, op_d;
    logic [15:0]    addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     rdata_q, rdata_d;
    logic [1:0]     idx_q, idx_d;
    logic           phase_q, phase_d;
    logic           in_rx;
    logic           tmo_expired;

    assign in_rx = (state_q == ST_RX_WAIT);

    updi_resp_timer #(
        .RESP_TIMEOUT_CLK(RESP_TIMEOUT_CLK)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!in_rx),
        .en_i     (in_rx),
        .expired_o(tmo_expired)
    );

    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;
    assign tx_data    = (state_q == ST_TX)
                      ? tx_byte(op_q, phase_q, idx_q, addr_q, wdata_q)
                      : 8'h00;

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        cmd_ready = 1'b0;
        tx_wr_en  = 1'b0;
        rx_rd_en  = 1'b0;
        brk_start = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    rdata_d  = 8'h00;
                    idx_d    = 2'd0;
                    phase_d  = 1'b0;
                    status_d = RSP_OK;
                    case (cmd_op)
                        CMD_BREAK: state_d = ST_BRK_START;
                        CMD_LDCS, CMD_STCS, CMD_LDS, CMD_STS:
                            state_d = ST_FLUSH;
                        default: begin
                            status_d = RSP_NACK;
                            state_d  = ST_DONE;
                        end
                    endcase
                end
            end
            ST_FLUSH: begin
                if (!rx_empty) begin
                    rx_rd_en = 1'b1;
                end else begin
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                if (!tx_full) begin
                    tx_wr_en = 1'b1;
                    if (idx_q == tx_last_idx(op_q, phase_q)) begin
                        idx_d   = 2'd0;
                        state_d = (op_q == CMD_STCS) ? ST_DONE : ST_RX_WAIT;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_RX_WAIT: begin
                if (rx_error) begin
                    rx_rd_en = !rx_empty;
                    if (!rx_empty) begin
                        rdata_d = rx_data;
                    end
                    status_d = RSP_RXERR;
                    state_d  = ST_DONE;
                end else if (!rx_empty) begin
                    rx_rd_en = 1'b1;
                    rdata_d  = rx_data;
                    state_d  = ST_CHECK;
                end else if (tmo_expired) begin
                    status_d = RSP_TIMEOUT;
                    state_d  = ST_DONE;
                end
            end
            ST_CHECK: begin
                state_d  = ST_DONE;
                status_d = RSP_OK;
                if (op_q == CMD_STS) begin
                    if (rdata_q != UPDI_ACK) begin
                        status_d = RSP_NACK;
                    end else if (!phase_q) begin
                        phase_d = 1'b1;
                        idx_d   = 2'd0;
                        state_d = ST_TX;
                    end
                end
            end
            ST_BRK_START: begin
                if (!brk_busy) begin
                    brk_start = 1'b1;
                    state_d   = ST_BRK_WAIT;
                end
            end
            ST_BRK_WAIT: begin
                if (brk_done) begin
                    status_d = RSP_OK;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            status_q <= RSP_OK;
            op_q     <= 3'd0;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            idx_q    <= 2'd0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
        end
    end

endmodule

// File: tb/tb_updi_instr_sequencer.sv
// tb_updi_instr_sequencer: directed bench with a FIFO/PHY model and a
// transaction-level model of the expected TX bytes and response.
module tb_updi_instr_sequencer;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_addr = 16'h0;
    logic [7:0]  cmd_wdata = 8'h0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_status;
    logic [7:0]  tx_data;
    logic        tx_wr_en;
    logic        tx_full = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_rd_en;
    logic        rx_empty = 1'b1;
    logic        rx_error = 1'b0;
    logic        brk_start;
    logic        brk_busy = 1'b0;
    logic        brk_done = 1'b0;

    updi_instr_sequencer #(.RESP_TIMEOUT_CLK(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status),
        .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_full(tx_full),
        .rx_data(rx_data), .rx_rd_en(rx_rd_en), .rx_empty(rx_empty),
        .rx_error(rx_error),
        .brk_start(brk_start), .brk_busy(brk_busy), .brk_done(brk_done)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not allowed here", name);
    endtask

    // PHY / expectation state shared by the monitor and stimulus.
    logic [7:0] rx_q[$];
    logic [7:0] stale_q[$];
    logic [7:0] plan_b[$];
    int         plan_t[$];
    bit         plan_e[$];
    logic [7:0] exp_tx[$];
    logic [7:0] tx_log[$];
    logic [1:0] exp_status;
    logic [7:0] exp_rdata;
    bit         exp_rdata_chk;
    bit         busy = 0;
    int cyc = 0, wr_cnt = 0, pops_before_wr = 0, pop_cnt = 0;
    int brk_pulses = 0, rsp_cnt = 0, dly = 0;
    int acc_cyc, first_wr_cyc, last_wr_cyc, rsp_cyc, brk_done_cyc;
    int wr5_cyc, ack_pop_cyc;
    logic [7:0] last_rdata;
    logic [1:0] last_status;

    // Compare process: checks outputs every negedge, updates FIFOs after posedge.
    initial begin : mon
        bit s_wr, s_rd, s_acc;
        forever begin
            @(negedge clk);
            cyc++;
            s_wr = 0; s_rd = 0; s_acc = 0;
            if (!rst) begin
                busy = 0;
                exp_tx.delete();
            end else begin
                chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, !busy});
                if (tx_wr_en) begin
                    chk("wr_while_full", {31'b0, tx_full}, 0);
                    if (exp_tx.size() == 0) fail_now("tx_extra");
                    else chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
                    tx_log.push_back(tx_data);
                    if (wr_cnt == 0) first_wr_cyc = cyc;
                    if (wr_cnt == 4) wr5_cyc = cyc;
                    last_wr_cyc = cyc;
                    s_wr = 1;
                end
                if (rx_rd_en) begin
                    chk("rd_while_empty", {31'b0, rx_empty}, 0);
                    if (wr_cnt == 0) pops_before_wr++;
                    if (wr_cnt == 4) ack_pop_cyc = cyc;
                    pop_cnt++;
                    s_rd = 1;
                end
                if (brk_start) brk_pulses++;
                if (brk_done) brk_done_cyc = cyc;
                if (rsp_valid) begin
                    chk("rsp_when_busy", {31'b0, busy}, 1);
                    chk("rsp_status", {30'b0, rsp_status}, {30'b0, exp_status});
                    if (exp_rdata_chk)
                        chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, exp_rdata});
                    chk("tx_missing", exp_tx.size(), 0);
                    last_rdata  = rsp_rdata;
                    last_status = rsp_status;
                    rsp_cyc = cyc;
                    rsp_cnt++;
                    busy = 0;
                end
                if (cmd_valid && cmd_ready) begin
                    busy = 1;
                    acc_cyc = cyc;
                    s_acc = 1;
                end
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                rx_q.delete();
                plan_b.delete(); plan_t.delete(); plan_e.delete();
                dly = 0;
            end
            if (s_acc) begin
                wr_cnt = 0; pops_before_wr = 0; pop_cnt = 0;
                brk_pulses = 0; tx_log.delete();
            end
            if (s_wr) wr_cnt++;
            if (s_rd && rx_q.size() > 0) void'(rx_q.pop_front());
            rx_error = 1'b0;
            while (stale_q.size() > 0) rx_q.push_back(stale_q.pop_front());
            if (plan_t.size() > 0 && wr_cnt >= plan_t[0]) begin
                dly++;
                if (dly >= 3) begin
                    rx_q.push_back(plan_b.pop_front());
                    rx_error = plan_e.pop_front();
                    void'(plan_t.pop_front());
                    dly = 0;
                end
            end else begin
                dly = 0;
            end
            rx_empty = (rx_q.size() == 0);
            rx_data  = rx_empty ? 8'h00 : rx_q[0];
        end
    end

    // Transaction model: expected TX bytes, status and read data.
    task automatic model(input logic [2:0] op, input logic [15:0] a,
                         input logic [7:0] wd, input int nr,
                         input logic [7:0] r0, input bit e0,
                         input logic [7:0] r1);
        exp_tx.delete();
        exp_status = 2'd0; exp_rdata = 8'h00; exp_rdata_chk = 1;
        case (op)
            3'd0: ;
            3'd1, 3'd3: begin
                exp_tx.push_back(8'h55);
                if (op == 3'd1) begin
                    exp_tx.push_back(8'h80 | {4'h0, a[3:0]});
                end else begin
                    exp_tx.push_back(8'h04);
                    exp_tx.push_back(a[7:0]);
                    exp_tx.push_back(a[15:8]);
                end
                if (nr == 0) exp_status = 2'd1;
                else if (e0) begin exp_status = 2'd2; exp_rdata_chk = 0; end
                else exp_rdata = r0;
            end
            3'd2: begin
                exp_tx.push_back(8'h55);
                exp_tx.push_back(8'hC0 | {4'h0, a[3:0]});
                exp_tx.push_back(wd);
            end
            3'd4: begin
                exp_tx.push_back(8'h55); exp_tx.push_back(8'h44);
                exp_tx.push_back(a[7:0]); exp_tx.push_back(a[15:8]);
                if (nr == 0) exp_status = 2'd1;
                else if (e0) begin exp_status = 2'd2; exp_rdata_chk = 0; end
                else if (r0 != 8'h40) begin exp_status = 2'd3; exp_rdata = r0; end
                else begin
                    exp_tx.push_back(wd);
                    exp_rdata = r0;
                    if (nr < 2) exp_status = 2'd1;
                    else if (r1 != 8'h40) begin exp_status = 2'd3; exp_rdata = r1; end
                    else exp_rdata = r1;
                end
            end
            default: exp_status = 2'd3;
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a,
                         input logic [7:0] wd, input int nr,
                         input logic [7:0] r0, input bit e0,
                         input logic [7:0] r1);
        model(op, a, wd, nr, r0, e0, r1);
        cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        if (nr > 0) begin
            plan_t.push_back(op == 3'd1 ? 2 : 4);
            plan_b.push_back(r0); plan_e.push_back(e0);
        end
        if (nr > 1) begin
            plan_t.push_back(5); plan_b.push_back(r1); plan_e.push_back(1'b0);
        end
    endtask

    task automatic wait_rsp(input int budget);
        int start;
        start = rsp_cnt;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (rsp_cnt != start) return;
        end
        fail_now("rsp_wait_expired");
    endtask

    task automatic wait_wr(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (wr_cnt >= n) return;
            tick(1);
        end
        fail_now("wr_wait_expired");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        int hold;
        tick(3);
        rst = 1'b1;
        tick(2);

        // Reset state.
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("rst_outs", {tx_wr_en, rx_rd_en, brk_start, rsp_valid,
                         rsp_rdata, rsp_status, tx_data}, 0);

        // LDCS a=0, response 0x30.
        issue(3'd1, 16'h0000, 8'h00, 1, 8'h30, 0, 8'h00);
        wait_rsp(100);
        chk("ldcs_rdata", {24'b0, last_rdata}, 32'h30);
        chk("ldcs_status", {30'b0, last_status}, 0);
        chk("ldcs_len", tx_log.size(), 2);
        chk("ldcs_b1", {24'b0, tx_log[1]}, 32'h80);
        chk("ldcs_lat", first_wr_cyc - acc_cyc, 2);
        tick(1);

        // STS 0x1234 <- 0xA5, both ACKs.
        issue(3'd4, 16'h1234, 8'hA5, 2, 8'h40, 0, 8'h40);
        wait_rsp(200);
        chk("sts_status", {30'b0, last_status}, 0);
        chk("sts_len", tx_log.size(), 5);
        chk("sts_b2", {24'b0, tx_log[2]}, 32'h34);
        chk("sts_b3", {24'b0, tx_log[3]}, 32'h12);
        chk("sts_b4", {24'b0, tx_log[4]}, 32'hA5);
        chk("sts_data_after_ack", {31'b0, wr5_cyc > ack_pop_cyc}, 1);
        tick(1);

        // STS NACK on phase 1.
        issue(3'd4, 16'h1234, 8'hA5, 1, 8'h00, 0, 8'h00);
        wait_rsp(200);
        chk("nack_status", {30'b0, last_status}, 3);
        chk("nack_rdata", {24'b0, last_rdata}, 0);
        chk("nack_len", tx_log.size(), 4);
        tick(1);

        // LDS with no response: timeout.
        issue(3'd3, 16'h0100, 8'h00, 0, 8'h00, 0, 8'h00);
        wait_rsp(200);
        chk("tmo_status", {30'b0, last_status}, 1);
        chk("tmo_gap", rsp_cyc - last_wr_cyc, TMO + 1);
        tick(1);

        // BREAK.
        issue(3'd0, 16'h0000, 8'h00, 0, 8'h00, 0, 8'h00);
        tick(4);
        chk("brk_pulses", brk_pulses, 1);
        brk_done = 1'b1;
        tick(1);
        brk_done = 1'b0;
        wait_rsp(20);
        chk("brk_lat", rsp_cyc - brk_done_cyc, 1);
        chk("brk_status", {30'b0, last_status}, 0);
        chk("brk_fifo", tx_log.size() + pop_cnt, 0);
        tick(1);

        // LDS with tx_full held for 10 cycles mid-list.
        issue(3'd3, 16'h2040, 8'h00, 1, 8'h77, 0, 8'h00);
        wait_wr(2, 20);
        tx_full = 1'b1;
        hold = wr_cnt;
        tick(10);
        chk("full_hold", wr_cnt, hold);
        tx_full = 1'b0;
        wait_rsp(200);
        chk("full_b2", {24'b0, tx_log[2]}, 32'h40);
        chk("full_b3", {24'b0, tx_log[3]}, 32'h20);
        chk("full_rdata", {24'b0, last_rdata}, 32'h77);
        tick(1);

        // LDCS with rx_error on the response byte.
        issue(3'd1, 16'h0003, 8'h00, 1, 8'h11, 1, 8'h00);
        wait_rsp(100);
        chk("rxerr_status", {30'b0, last_status}, 2);
        chk("rxerr_popped", {31'b0, rx_empty}, 1);
        tick(1);

        // Illegal op.
        issue(3'd6, 16'h0000, 8'h00, 0, 8'h00, 0, 8'h00);
        wait_rsp(10);
        chk("ill_status", {30'b0, last_status}, 3);
        chk("ill_lat", rsp_cyc - acc_cyc, 1);
        chk("ill_fifo", tx_log.size() + pop_cnt, 0);
        tick(1);

        // STCS a=4 <- 0x9C.
        issue(3'd2, 16'h0004, 8'h9C, 0, 8'h00, 0, 8'h00);
        wait_rsp(50);
        chk("stcs_status", {30'b0, last_status}, 0);
        chk("stcs_b1", {24'b0, tx_log[1]}, 32'hC4);
        tick(1);

        // Reset during RX_WAIT.
        issue(3'd3, 16'h0055, 8'h00, 0, 8'h00, 0, 8'h00);
        wait_wr(4, 20);
        tick(5);
        rst = 1'b0;
        tick(1);
        chk("rstmid_outs", {tx_wr_en, rx_rd_en, brk_start, rsp_valid,
                            rsp_rdata, rsp_status, tx_data}, 0);
        hold = rsp_cnt;
        tick(1);
        rst = 1'b1;
        tick(TMO + 10);
        chk("rstmid_no_rsp", rsp_cnt, hold);

        // Two stale bytes, then LDCS: stale bytes flushed first.
        stale_q.push_back(8'hEE);
        stale_q.push_back(8'hDD);
        tick(1);
        issue(3'd1, 16'h0002, 8'h00, 1, 8'h5A, 0, 8'h00);
        wait_rsp(100);
        chk("stale_pops", pops_before_wr, 2);
        chk("stale_lat", first_wr_cyc - acc_cyc, 4);
        chk("stale_rdata", {24'b0, last_rdata}, 32'h5A);
        chk("stale_b1", {24'b0, tx_log[1]}, 32'h82);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
